// File: rtl/ccc_reconfig_pkg.sv
// Shared types and constants for the CCC dynamic-configuration APB initiator.
package ccc_reconfig_pkg;
  localparam int ADDR_W      = 6;
  localparam int DATA_W      = 8;
  localparam int LOCK_IGNORE = 3;

  typedef enum logic [3:0] {
    IDLE, WAIT_BUSY, SETUP, ACCESS, RD_SETUP, RD_ACCESS,
    CHECK, POP, PLL_RST, WAIT_LOCK, DONE, ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_BUSY   = 2'd1;
  localparam logic [1:0] ERR_VERIFY = 2'd2;
  localparam logic [1:0] ERR_LOCK   = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cfg_entry_t;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/ccc_apb_reconfig_if.sv
// APB link between the reconfig initiator and the CCC dynamic-config port.
interface ccc_apb_reconfig_if;
  logic                                 PSEL;
  logic                                 PENABLE;
  logic                                 PWRITE;
  logic [ccc_reconfig_pkg::ADDR_W-1:0]  PADDR;
  logic [ccc_reconfig_pkg::DATA_W-1:0]  PWDATA;
  logic [ccc_reconfig_pkg::DATA_W-1:0]  PRDATA;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA);
endinterface

// File: rtl/ccc_cfg_fifo.sv
// Write queue of {addr, data} entries; head is valid whenever the queue is non-empty.
module ccc_cfg_fifo
  import ccc_reconfig_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  cfg_entry_t din,
  output cfg_entry_t head,
  output logic       full,
  output logic       empty,
  output logic       one_left
);
  localparam int PW = $clog2(DEPTH);

  cfg_entry_t    mem [DEPTH];
  logic [PW:0]   wptr, rptr, count;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count    = wptr - rptr;
  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign one_left = (count == (PW+1)'(1));
  assign head     = mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (PW+1)'(1);
      if (pop && !empty) rptr <= rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[PW-1:0]] <= din;
  end
endmodule

// File: rtl/ccc_apb_reconfig.sv
// APB initiator for the CCC dynamic-config port: streams queued register writes,
// optionally reads each back, then pulses PLL reset and waits for LOCK.
module ccc_apb_reconfig
  import ccc_reconfig_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int VERIFY       = 1,
  parameter int BUSY_TIMEOUT = 1024,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               go,
  output logic               active,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  ccc_apb_reconfig_if.master apb,
  input  logic               CCC_BUSY,
  input  logic               LOCK,
  output logic               PLL_ARST_N
);
  localparam int CNT_W = $clog2(max3(BUSY_TIMEOUT, RST_CYCLES, LOCK_TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] IGN_CNT   = CNT_W'(LOCK_IGNORE);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        code_nxt;
  logic              code_set;
  logic              lock_meta, lock_sync;
  logic [DATA_W-1:0] rd_data;
  cfg_entry_t        head, wr_entry;
  logic              full, empty, one_left;
  logic              push, pop, go_ok, apb_on, apb_wr;

  assign wr_entry = '{addr: wr_addr, data: wr_data};
  assign push     = wr_valid & wr_ready;
  // A push in the go cycle counts, so go on an empty queue plus push still starts.
  assign go_ok    = go & (state == IDLE) & (~empty | push);

  ccc_cfg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (PCLK),
    .rst      (PRESET),
    .push     (push),
    .pop      (pop),
    .flush    (state == ERROR),
    .din      (wr_entry),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .one_left (one_left)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    code_set  = 1'b0;
    code_nxt  = ERR_NONE;
    case (state)
      IDLE:      if (go_ok) state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!CCC_BUSY) state_nxt = SETUP;
        else if (cnt == BUSY_LAST) begin
          state_nxt = ERROR;
          code_set  = 1'b1;
          code_nxt  = ERR_BUSY;
        end
      end
      SETUP:     state_nxt = ACCESS;
      ACCESS:    state_nxt = (VERIFY != 0) ? RD_SETUP : POP;
      RD_SETUP:  state_nxt = RD_ACCESS;
      RD_ACCESS: state_nxt = CHECK;
      CHECK: begin
        if (rd_data != head.data) begin
          state_nxt = ERROR;
          code_set  = 1'b1;
          code_nxt  = ERR_VERIFY;
        end else begin
          state_nxt = POP;
        end
      end
      POP: begin
        pop       = 1'b1;
        state_nxt = one_left ? PLL_RST : WAIT_BUSY;
      end
      PLL_RST:   if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      // The first cycles after release still see the pre-reset LOCK through the synchroniser.
      WAIT_LOCK: begin
        if (cnt >= IGN_CNT && lock_sync) state_nxt = DONE;
        else if (cnt == LOCK_LAST) begin
          state_nxt = ERROR;
          code_set  = 1'b1;
          code_nxt  = ERR_LOCK;
        end
      end
      DONE:      state_nxt = IDLE;
      ERROR:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      cnt       <= '0;
      err_code  <= ERR_NONE;
      rd_data   <= '0;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_meta <= LOCK;
      lock_sync <= lock_meta;
      // One shared counter: restarts on every state change, saturates otherwise.
      if (state_nxt != state) cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + CNT_W'(1);
      if (go_ok)         err_code <= ERR_NONE;
      else if (code_set) err_code <= code_nxt;
      if (state == RD_ACCESS) rd_data <= apb.PRDATA;
    end
  end

  assign apb_on      = state inside {SETUP, ACCESS, RD_SETUP, RD_ACCESS};
  assign apb_wr      = state inside {SETUP, ACCESS};
  assign apb.PSEL    = apb_on;
  assign apb.PENABLE = (state == ACCESS) || (state == RD_ACCESS);
  assign apb.PWRITE  = apb_wr;
  assign apb.PADDR   = apb_on ? head.addr : '0;
  assign apb.PWDATA  = apb_wr ? head.data : '0;

  assign active     = (state != IDLE);
  assign wr_ready   = (state == IDLE) && !full;
  assign done       = (state == DONE);
  assign err        = (state == ERROR);
  assign PLL_ARST_N = (state != PLL_RST);
endmodule

// File: tb/tb_ccc_apb_reconfig.sv
// Directed bench: one initiator without verify (u0), one with verify (u1) against a register model.
module tb_ccc_apb_reconfig;
  localparam int BT = 20;
  localparam int RC = 16;
  localparam int LT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic wv0 = 0, wv1 = 0, go0 = 0, go1 = 0, busy = 0, lock = 0, corrupt = 0;
  logic rdy0, rdy1, act0, act1, done0, done1, err0, err1, arst0, arst1;
  logic [1:0] ec0, ec1;

  ccc_apb_reconfig_if a0();
  ccc_apb_reconfig_if a1();

  ccc_apb_reconfig #(.FIFO_DEPTH(16), .VERIFY(0), .BUSY_TIMEOUT(BT), .RST_CYCLES(RC),
                     .LOCK_TIMEOUT(LT)) u0 (
    .PCLK(clk), .PRESET(rst), .wr_valid(wv0), .wr_ready(rdy0), .wr_addr(wr_addr),
    .wr_data(wr_data), .go(go0), .active(act0), .done(done0), .err(err0), .err_code(ec0),
    .apb(a0), .CCC_BUSY(busy), .LOCK(lock), .PLL_ARST_N(arst0));

  ccc_apb_reconfig #(.FIFO_DEPTH(16), .VERIFY(1), .BUSY_TIMEOUT(BT), .RST_CYCLES(RC),
                     .LOCK_TIMEOUT(LT)) u1 (
    .PCLK(clk), .PRESET(rst), .wr_valid(wv1), .wr_ready(rdy1), .wr_addr(wr_addr),
    .wr_data(wr_data), .go(go1), .active(act1), .done(done1), .err(err1), .err_code(ec1),
    .apb(a1), .CCC_BUSY(busy), .LOCK(lock), .PLL_ARST_N(arst1));

  // CCC register model behind u1; corrupt zeroes the second read after reset.
  logic [7:0]  smem [64];
  int          rd_cnt;
  logic [14:0] ops1 [$];
  assign a0.PRDATA = 8'h00;
  assign a1.PRDATA = (corrupt && rd_cnt == 1) ? 8'h00 : smem[a1.PADDR];

  always @(posedge clk) begin
    if (a1.PSEL && a1.PENABLE && a1.PWRITE) smem[a1.PADDR] <= a1.PWDATA;
    if (rst) rd_cnt <= 0;
    else if (a1.PSEL && a1.PENABLE && !a1.PWRITE) rd_cnt <= rd_cnt + 1;
    if (a1.PSEL && a1.PENABLE)
      ops1.push_back({a1.PWRITE, a1.PADDR, a1.PWRITE ? a1.PWDATA : a1.PRDATA});
  end

  int          psel0_cnt = 0, wr0_cnt = 0;
  logic [13:0] last_wr0 = '0;
  always @(posedge clk) begin
    if (a0.PSEL) psel0_cnt <= psel0_cnt + 1;
    if (a0.PSEL && a0.PENABLE && a0.PWRITE) begin
      wr0_cnt  <= wr0_cnt + 1;
      last_wr0 <= {a0.PADDR, a0.PWDATA};
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit which, input logic [5:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    if (which) wv1 = 1; else wv0 = 1;
    tick();
    wv0 = 0;
    wv1 = 0;
  endtask

  task automatic pulse_go(input bit which);
    if (which) go1 = 1; else go0 = 1;
    tick();
    go0 = 0;
    go1 = 0;
  endtask

  function automatic logic [16:0] apb0();
    return {a0.PSEL, a0.PENABLE, a0.PWRITE, a0.PADDR, a0.PWDATA};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    bit ok, seen;
    for (int i = 0; i < 64; i++) smem[i] = 8'h00;

    // reset state
    repeat (3) tick();
    chk("rst_apb", apb0(), 17'h0);
    chk("rst_ctl", {arst0, act0, done0, err0, ec0, rdy0}, {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1});
    rst = 0;
    tick();

    // u0 basic: two writes, exact APB phases, PLL reset width, lock -> done
    push(0, 6'h03, 8'hA5);
    push(0, 6'h04, 8'h5A);
    pulse_go(0);
    chk("t1_active", act0, 1);
    chk("t1_wbusy", apb0(), 17'h0);
    tick(); chk("t1_setup1",  apb0(), {1'b1, 1'b0, 1'b1, 6'h03, 8'hA5});
    tick(); chk("t1_access1", apb0(), {1'b1, 1'b1, 1'b1, 6'h03, 8'hA5});
    tick(); chk("t1_pop1",    apb0(), 17'h0);
    tick();
    tick(); chk("t1_setup2",  apb0(), {1'b1, 1'b0, 1'b1, 6'h04, 8'h5A});
    tick(); chk("t1_access2", apb0(), {1'b1, 1'b1, 1'b1, 6'h04, 8'h5A});
    tick();
    tick(); chk("t1_arst_lo", arst0, 0);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (arst0) break;
      n++;
    end
    chk("t1_arst_width", n, RC);
    repeat (5) tick();
    lock = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done0) begin ok = 1; break; end
    end
    chk("t1_done", ok, 1);
    chk("t1_ec", ec0, 0);
    tick();
    chk("t1_idle", act0, 0);

    // u1 verify with mirroring slave; LOCK already high -> done exactly after ignore window
    base = ops1.size();
    push(1, 6'h03, 8'hA5);
    push(1, 6'h04, 8'h5A);
    pulse_go(1);
    for (int i = 0; i < 40; i++) begin
      if (!arst1) break;
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      if (arst1) break;
      tick();
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (done1) break;
    end
    chk("t2_lock_ign", n, 4);
    chk("t2_ec", ec1, 0);
    chk("t2_nops", ops1.size() - base, 4);
    chk("t2_op0", ops1[base],     {1'b1, 6'h03, 8'hA5});
    chk("t2_op1", ops1[base + 1], {1'b0, 6'h03, 8'hA5});
    chk("t2_op2", ops1[base + 2], {1'b1, 6'h04, 8'h5A});
    chk("t2_op3", ops1[base + 3], {1'b0, 6'h04, 8'h5A});
    lock = 0;

    // u1 verify mismatch on entry 2
    rst = 1; tick(); rst = 0; tick();
    corrupt = 1;
    push(1, 6'h10, 8'h11);
    push(1, 6'h20, 8'h22);
    push(1, 6'h30, 8'h33);
    pulse_go(1);
    ok = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!arst1) seen = 1;
      if (err1) begin ok = 1; break; end
    end
    chk("t3_err", ok, 1);
    chk("t3_ec", ec1, 2);
    chk("t3_no_arst", seen, 0);
    tick();
    chk("t3_idle", act1, 0);
    pulse_go(1);
    chk("t3_fifo_empty", act1, 0);
    chk("t3_ec_hold", ec1, 2);
    corrupt = 0;

    // u0 busy timeout
    busy = 1;
    push(0, 6'h05, 8'h01);
    base = psel0_cnt;
    pulse_go(0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (err0) break;
    end
    chk("t4_busy_to", n, BT);
    chk("t4_ec", ec0, 1);
    chk("t4_no_apb", psel0_cnt - base, 0);
    busy = 0;
    tick();

    // u0 lock timeout; push and go in the same cycle on an empty queue
    wr_addr = 6'h06; wr_data = 8'h02; wv0 = 1; go0 = 1;
    tick();
    wv0 = 0; go0 = 0;
    chk("t5_push_go", act0, 1);
    for (int i = 0; i < 40; i++) begin
      if (!arst0) break;
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      if (arst0) break;
      tick();
    end
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (err0) break;
    end
    chk("t5_lock_to", n, LT);
    chk("t5_ec", ec0, 3);
    tick();
    chk("t5_arst_hi", {arst0, act0}, {1'b1, 1'b0});

    // go with empty queue is ignored
    pulse_go(0);
    chk("t6_go_empty", act0, 0);

    // fill queue; 17th push rejected; go while active ignored
    lock = 1;
    for (int i = 0; i < 16; i++) push(0, 6'(i), 8'(8'h80 + i));
    chk("t6_full", rdy0, 0);
    push(0, 6'h3F, 8'hFF);
    base = wr0_cnt;
    pulse_go(0);
    repeat (10) tick();
    chk("t6_rdy_active", rdy0, 0);
    pulse_go(0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done0) begin ok = 1; break; end
    end
    chk("t6_done", ok, 1);
    chk("t6_nwr", wr0_cnt - base, 16);
    chk("t6_last", last_wr0, {6'd15, 8'h8F});
    chk("t6_ec_clr", ec0, 0);
    lock = 0;
    tick();

    // reset during ACCESS of entry 3
    push(0, 6'h21, 8'h01);
    push(0, 6'h22, 8'h02);
    push(0, 6'h23, 8'h03);
    push(0, 6'h24, 8'h04);
    pulse_go(0);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (a0.PSEL && a0.PENABLE && a0.PADDR == 6'h23) begin ok = 1; break; end
      tick();
    end
    chk("t7_reach", ok, 1);
    rst = 1;
    tick();
    chk("t7_abort", {a0.PSEL, a0.PENABLE, act0, rdy0}, {1'b0, 1'b0, 1'b0, 1'b1});
    rst = 0;
    tick();
    pulse_go(0);
    chk("t7_flushed", act0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
